multicycle_controller: RTL

- Multicycle control FSM directly upstream of the 16-bit datapath.
- Consumes the latched instruction and PSR, and drives every datapath enable, mux select, ALU/shifter code and PC mode, plus the memory write strobe.
- Implements the CR16-style baseline ISA: R-type, immediate, shift, LOAD/STOR, Bcond, Jcond, JAL.

---
 rtl/multicycle_controller_pkg.sv | 150 +++++++++++++++
 rtl/cond_eval.sv | 42 ++++
 rtl/multicycle_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: states, opcode/ext fields, ALU and shifter codes,
// enable/select bit positions, PSR flag positions, and the instruction classifier.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    WB     = 4'd3,
    LOAD   = 4'd4,
    STORE  = 4'd5,
    BRANCH = 4'd6,
    JUMP   = 4'd7,
    JAL    = 4'd8,
    JAL_WB = 4'd9
  } state_t;

  // Major opcodes in instr[15:12]
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_BCOND = 4'hC;

  // ALU function field: R-type ext and the immediate-form opcode share one encoding
  localparam logic [3:0] FN_AND = 4'h1;
  localparam logic [3:0] FN_OR  = 4'h2;
  localparam logic [3:0] FN_XOR = 4'h3;
  localparam logic [3:0] FN_ADD = 4'h5;
  localparam logic [3:0] FN_SUB = 4'h9;
  localparam logic [3:0] FN_CMP = 4'hB;
  localparam logic [3:0] FN_MOV = 4'hD;
  localparam logic [3:0] FN_LUI = 4'hF;

  // ext field under OP_SHIFT and OP_MEM
  localparam logic [3:0] EXT_LSHI_L = 4'h0;
  localparam logic [3:0] EXT_LSHI_R = 4'h1;
  localparam logic [3:0] EXT_LSH    = 4'h4;
  localparam logic [3:0] EXT_LOAD   = 4'h0;
  localparam logic [3:0] EXT_STOR   = 4'h4;
  localparam logic [3:0] EXT_JAL    = 4'h8;
  localparam logic [3:0] EXT_JCOND  = 4'hC;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_CMP = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_MOV = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  localparam logic [1:0] RES_SHIFT = 2'b00;
  localparam logic [1:0] RES_ALU   = 2'b01;
  localparam logic [1:0] RES_PCALU = 2'b10;
  localparam logic [1:0] RES_LINK  = 2'b11;

  localparam int EN_PCEN   = 6;
  localparam int EN_PSREN  = 5;
  localparam int EN_NEXTI  = 4;
  localparam int EN_REGW   = 3;
  localparam int EN_RESULT = 2;
  localparam int EN_IMMREG = 1;
  localparam int EN_MEMW   = 0;

  localparam int SEL_UPDADDR  = 6;
  localparam int SEL_STOREREG = 5;
  localparam int SEL_WRDATA   = 4;
  localparam int SEL_ZEXT     = 3;
  localparam int SEL_PCINSTR  = 2;
  localparam int SEL_REGDEST  = 1;
  localparam int SEL_SRCB     = 0;

  localparam int PCM_JUMP   = 2;
  localparam int PCM_BRANCH = 1;
  localparam int PCM_JAL    = 0;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_SHIFT, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_JAL, CLS_ILLEGAL
  } instrClass_t;

  typedef struct packed {
    instrClass_t cls;
    logic [3:0]  aluCond;
    logic        isImm;
    logic        zeroExt;
    logic        setsPsr;
    logic        isCmp;
    logic        shiftLeft;
  } decoded_t;

  function automatic decoded_t decodeInstr(input logic [3:0] op, input logic [3:0] ext);
    decoded_t d;
    logic [3:0] fn;
    logic fnOk;
    d = '0;
    d.cls = CLS_ILLEGAL;
    d.aluCond = ALU_ADD;
    fn = (op == OP_RTYPE) ? ext : op;
    fnOk = 1'b1;
    case (fn)
      FN_ADD: d.aluCond = ALU_ADD;
      FN_SUB: d.aluCond = ALU_SUB;
      FN_CMP: d.aluCond = ALU_CMP;
      FN_AND: d.aluCond = ALU_AND;
      FN_OR:  d.aluCond = ALU_OR;
      FN_XOR: d.aluCond = ALU_XOR;
      FN_MOV: d.aluCond = ALU_MOV;
      // LUI has only an immediate form
      FN_LUI: begin
        d.aluCond = ALU_LUI;
        fnOk = (op != OP_RTYPE);
      end
      default: fnOk = 1'b0;
    endcase
    case (op)
      OP_MEM: begin
        case (ext)
          EXT_LOAD:  d.cls = CLS_LOAD;
          EXT_STOR:  d.cls = CLS_STORE;
          EXT_JAL:   d.cls = CLS_JAL;
          EXT_JCOND: d.cls = CLS_JUMP;
          default:   d.cls = CLS_ILLEGAL;
        endcase
      end
      OP_SHIFT: begin
        d.isImm = (ext != EXT_LSH);
        d.shiftLeft = (ext == EXT_LSHI_L);
        if (ext == EXT_LSH || ext == EXT_LSHI_L || ext == EXT_LSHI_R) d.cls = CLS_SHIFT;
      end
      OP_BCOND: d.cls = CLS_BRANCH;
      default: begin
        if (fnOk) begin
          d.cls = CLS_ALU;
          d.isImm = (op != OP_RTYPE);
          d.setsPsr = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_CMP);
          d.isCmp = (fn == FN_CMP);
          d.zeroExt = d.isImm && ((fn == FN_AND) || (fn == FN_OR) || (fn == FN_XOR));
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Evaluates a 4-bit branch/jump condition code against the PSR flags.
module cond_eval
  import multicycle_controller_pkg::*;
(
  input  logic [7:0] psr,
  input  logic [3:0] cond,
  output logic       take
);

  logic c, l, f, z, n;
  logic unusedPsr;

  assign c = psr[PSR_C];
  assign l = psr[PSR_L];
  assign f = psr[PSR_F];
  assign z = psr[PSR_Z];
  assign n = psr[PSR_N];
  assign unusedPsr = ^{psr[4:3], psr[1]};

  always_comb begin
    take = 1'b0;
    case (cond)
      4'h0: take = z;
      4'h1: take = !z;
      4'h2: take = c;
      4'h3: take = !c;
      4'h4: take = l;
      4'h5: take = !l;
      4'h6: take = n;
      4'h7: take = !n;
      4'h8: take = f;
      4'h9: take = !f;
      4'hA: take = !l && !z;
      4'hB: take = l || z;
      4'hC: take = !n && !z;
      4'hD: take = n || z;
      4'hE: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/writeback and drives every datapath
// enable, select, ALU/shifter code and PC mode from the current state and latched instruction.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int STATEBITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     instr,
  input  logic [7:0]           psr,
  input  logic                 memWait,
  output logic [6:0]           en,
  output logic [6:0]           sel,
  output logic [2:0]           pcMode,
  output logic [3:0]           ALUcond,
  output logic [3:0]           shifterControl,
  output logic [3:0]           shiftAmt,
  output logic [1:0]           chooseResult,
  output logic [STATEBITS-1:0] state,
  output logic                 illegal
);

  state_t   curState, nextState;
  decoded_t dec;
  logic     take;
  logic [6:0] enRaw;
  logic [2:0] pcModeRaw;
  logic       illegalRaw;

  assign dec = decodeInstr(instr[15:12], instr[7:4]);

  cond_eval uCondEval (
    .psr  (psr),
    .cond (instr[11:8]),
    .take (take)
  );

  always_ff @(posedge clk) begin
    if (reset) curState <= FETCH;
    else       curState <= nextState;
  end

  always_comb begin
    nextState      = curState;
    enRaw          = '0;
    sel            = '0;
    pcModeRaw      = '0;
    ALUcond        = ALU_ADD;
    shifterControl = '0;
    chooseResult   = RES_ALU;
    illegalRaw     = 1'b0;
    case (curState)
      FETCH: begin
        sel[SEL_UPDADDR] = 1'b1;
        if (!memWait) begin
          enRaw[EN_NEXTI] = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        // pc := pc + 1 happens here for every instruction, including undefined ones
        enRaw[EN_IMMREG] = 1'b1;
        enRaw[EN_PCEN]   = 1'b1;
        sel[SEL_PCINSTR] = 1'b1;
        sel[SEL_ZEXT]    = dec.zeroExt;
        case (dec.cls)
          CLS_ALU, CLS_SHIFT: nextState = EXEC;
          CLS_LOAD:           nextState = LOAD;
          CLS_STORE:          nextState = STORE;
          CLS_BRANCH:         nextState = BRANCH;
          CLS_JUMP:           nextState = JUMP;
          CLS_JAL:            nextState = JAL;
          default: begin
            illegalRaw = 1'b1;
            nextState  = FETCH;
          end
        endcase
      end
      EXEC: begin
        enRaw[EN_RESULT] = 1'b1;
        enRaw[EN_PSREN]  = dec.setsPsr;
        sel[SEL_SRCB]    = !dec.isImm;
        if (dec.cls == CLS_SHIFT) begin
          chooseResult   = RES_SHIFT;
          shifterControl = {2'b00, dec.isImm, dec.shiftLeft};
        end else begin
          ALUcond = dec.aluCond;
        end
        nextState = dec.isCmp ? FETCH : WB;
      end
      WB: begin
        enRaw[EN_REGW]  = 1'b1;
        sel[SEL_WRDATA] = 1'b1;
        nextState = FETCH;
      end
      LOAD: begin
        if (!memWait) begin
          enRaw[EN_REGW] = 1'b1;
          nextState = FETCH;
        end
      end
      STORE: begin
        sel[SEL_STOREREG] = 1'b1;
        enRaw[EN_MEMW]    = 1'b1;
        if (!memWait) nextState = FETCH;
      end
      BRANCH: begin
        if (take) begin
          sel[SEL_PCINSTR]      = 1'b1;
          pcModeRaw[PCM_BRANCH] = 1'b1;
          enRaw[EN_PCEN]        = 1'b1;
        end
        nextState = FETCH;
      end
      JUMP: begin
        if (take) begin
          sel[SEL_SRCB]       = 1'b1;
          pcModeRaw[PCM_JUMP] = 1'b1;
          enRaw[EN_PCEN]      = 1'b1;
        end
        nextState = FETCH;
      end
      JAL: begin
        // Link (incremented pc) is captured in the same cycle the pc is redirected to Rsrc
        chooseResult       = RES_LINK;
        enRaw[EN_RESULT]   = 1'b1;
        enRaw[EN_PCEN]     = 1'b1;
        sel[SEL_SRCB]      = 1'b1;
        pcModeRaw[PCM_JAL] = 1'b1;
        nextState = JAL_WB;
      end
      JAL_WB: begin
        chooseResult    = RES_LINK;
        enRaw[EN_REGW]  = 1'b1;
        sel[SEL_WRDATA] = 1'b1;
        nextState = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  // Reset suppresses every strobe combinationally so the reset edge itself writes nothing
  assign en       = reset ? '0 : enRaw;
  assign pcMode   = reset ? '0 : pcModeRaw;
  assign illegal  = reset ? 1'b0 : illegalRaw;
  assign shiftAmt = instr[3:0];
  assign state    = curState;

endmodule
